// File: rtl/scroll_display7seg.sv
// Scrolling 7-segment message display with multiplexed digit scan.
// Ports: clk, rst (sync, high), load/msg capture, en/dir scroll control,
// seg/an registered active-low drive, pos scroll offset, wrap pulse.
module scroll_display7seg #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int SCROLL_DIV = 50000000,
  parameter int MUX_DIV    = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [3*MSG_LEN-1:0]       msg,
  input  logic                       en,
  input  logic                       dir,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
  output logic [$clog2(MSG_LEN)-1:0] pos,
  output logic                       wrap
);

  localparam int PW = $clog2(MSG_LEN);
  localparam int SW = $clog2(SCROLL_DIV);
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
  localparam logic [SW-1:0] PRE_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    BLANK,
    SHOW,
    SCROLL
  } state_t;

  state_t state_q;
  state_t state_nx;

  logic [3*MSG_LEN-1:0] msg_q;
  logic [SW-1:0]        presc_q;
  logic [MW-1:0]        mux_q;
  logic [DW-1:0]        dig_q;

  logic          disp_on;
  logic          scroll_on;
  logic          tick;
  logic [PW-1:0] pos_nx;
  logic          wrap_nx;
  logic [2:0]    sym;
  int            idx;

  function automatic logic [6:0] decode(input logic [2:0] s);
    logic [6:0] d;
    d = SEG_OFF;
    unique casez (s)
      3'b000: d = 7'b0001001;
      3'b001: d = 7'b0000110;
      3'b010: d = 7'b1000111;
      3'b011: d = 7'b1000000;
      3'b1??: d = SEG_OFF;
    endcase
    return d;
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= BLANK;
    else     state_q <= state_nx;
  end

  // FSM: next state; a load pins the loaded states in place
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      BLANK:
        if (load) state_nx = en ? SCROLL : SHOW;
      SHOW:
        if (!load && en) state_nx = SCROLL;
      SCROLL:
        if (!load && !en) state_nx = SHOW;
      default:
        state_nx = BLANK;
    endcase
  end

  // FSM: outputs
  always_comb begin
    disp_on   = (state_q != BLANK);
    scroll_on = (state_q == SCROLL);
  end

  // Step and wrap use explicit compares so any MSG_LEN works.
  always_comb begin
    tick = scroll_on && (presc_q == PRE_LAST);
    if (dir) begin
      pos_nx  = (pos == '0) ? POS_LAST : pos - 1'b1;
      wrap_nx = (pos == '0);
    end else begin
      pos_nx  = (pos == POS_LAST) ? '0 : pos + 1'b1;
      wrap_nx = (pos == POS_LAST);
    end
  end

  // Message, offset and prescaler; load beats a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q   <= {MSG_LEN{3'b100}};
      pos     <= '0;
      presc_q <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        msg_q   <= msg;
        pos     <= '0;
        presc_q <= '0;
      end else if (scroll_on) begin
        if (tick) begin
          presc_q <= '0;
          pos     <= pos_nx;
          wrap    <= wrap_nx;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  // Symbol shown on the selected digit
  always_comb begin
    idx = (int'(pos) + int'(dig_q)) % MSG_LEN;
    sym = msg_q[3*idx +: 3];
  end

  // Scan runs in every state so a load never disturbs its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_q <= '0;
      dig_q <= '0;
      seg   <= SEG_OFF;
      an    <= '1;
    end else begin
      if (mux_q == MUX_LAST) begin
        mux_q <= '0;
        dig_q <= (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      end else begin
        mux_q <= mux_q + 1'b1;
      end
      seg <= disp_on ? decode(sym) : SEG_OFF;
      an  <= disp_on ? ~(ONE << dig_q) : '1;
    end
  end

endmodule

// File: tb/tb_scroll_display7seg.sv
// Directed bench for scroll_display7seg.
// NUM_DIGITS=4, MSG_LEN=4, SCROLL_DIV=8, MUX_DIV=2.
module tb_scroll_display7seg;

  localparam logic [6:0] S_H  = 7'b0001001;
  localparam logic [6:0] S_E  = 7'b0000110;
  localparam logic [6:0] S_L  = 7'b1000111;
  localparam logic [6:0] S_O  = 7'b1000000;
  localparam logic [6:0] S_BL = 7'b1111111;

  localparam logic [11:0] MSG_A = 12'b011_010_001_000;
  localparam logic [11:0] MSG_B = 12'b000_011_010_001;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] msg;
  logic        en;
  logic        dir;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  pos;
  logic        wrap;

  int vectors = 0;
  int errors  = 0;
  int cnt     = 0;
  int t0      = 0;

  scroll_display7seg #(
    .NUM_DIGITS(4),
    .MSG_LEN(4),
    .SCROLL_DIV(8),
    .MUX_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .msg(msg),
    .en(en),
    .dir(dir),
    .seg(seg),
    .an(an),
    .pos(pos),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_an(input logic [3:0] tgt, input int lim,
                         input string nm);
    int k;
    k = 0;
    while (an !== tgt && k < lim) begin
      cyc(1);
      k++;
    end
    vectors++;
    if (an !== tgt) begin
      errors++;
      $display("FAIL %s: an=%b want %b (timeout)", nm, an, tgt);
    end
  endtask

  task automatic test_reset;
    rst = 1; load = 0; en = 0; dir = 0; msg = '0;
    cyc(2);
    rst = 0;
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (an !== 4'b1111) begin
        errors++; $display("FAIL rst_an: an=%b want 1111", an);
      end
      vectors++;
      if (seg !== S_BL) begin
        errors++; $display("FAIL rst_seg: seg=%b want %b", seg, S_BL);
      end
      vectors++;
      if (pos !== 2'd0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL rst_pos: pos=%0d wrap=%b want 0 0", pos, wrap);
      end
      cyc(1);
    end
  endtask

  task automatic test_static;
    logic [6:0] tbl [4];
    logic [3:0] ea;
    tbl[0] = S_H; tbl[1] = S_E; tbl[2] = S_L; tbl[3] = S_O;
    load = 1; msg = MSG_A; en = 0;
    cyc(1);
    load = 0; msg = '0;
    wait_an(4'b0111, 20, "static_sync3");
    wait_an(4'b1110, 10, "static_sync0");
    for (int j = 0; j < 8; j++) begin
      ea = ~(4'b0001 << (j / 2));
      vectors++;
      if (an !== ea) begin
        errors++; $display("FAIL static_an: an=%b want %b", an, ea);
      end
      vectors++;
      if (seg !== tbl[j/2]) begin
        errors++;
        $display("FAIL static_seg: seg=%b want %b", seg, tbl[j/2]);
      end
      vectors++;
      if (pos !== 2'd0) begin
        errors++; $display("FAIL static_pos: pos=%0d want 0", pos);
      end
      cyc(1);
    end
  endtask

  task automatic test_left;
    logic [1:0] ep;
    logic       ew;
    bit         seen;
    en = 1; dir = 0;
    cyc(8);
    vectors++;
    if (pos !== 2'd0) begin
      errors++; $display("FAIL left_pre: pos=%0d want 0", pos);
    end
    cyc(1);
    vectors++;
    if (pos !== 2'd1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL left_tick1: pos=%0d wrap=%b want 1 0", pos, wrap);
    end
    t0 = cnt;
    seen = 0;
    for (int j = 1; j <= 25; j++) begin
      cyc(1);
      ep = 2'((1 + j / 8) % 4);
      ew = (j == 24);
      vectors++;
      if (pos !== ep || wrap !== ew) begin
        errors++;
        $display("FAIL left_run d=%0d: pos=%0d wrap=%b want %0d %b",
                 j, pos, wrap, ep, ew);
      end
      if (j < 8 && an === 4'b1110) begin
        seen = 1;
        vectors++;
        if (seg !== S_E) begin
          errors++; $display("FAIL left_dig0: seg=%b want %b", seg, S_E);
        end
      end
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL left_dig0_seen: got 0 want 1");
    end
  endtask

  task automatic test_right;
    int         d;
    logic [1:0] ep;
    logic       ew;
    bit         seen;
    dir = 1;
    seen = 0;
    d = cnt - t0;
    while (d < 39) begin
      cyc(1);
      d = cnt - t0;
      ep = (d < 32) ? 2'd0 : 2'd3;
      ew = (d == 32);
      vectors++;
      if (pos !== ep || wrap !== ew) begin
        errors++;
        $display("FAIL right_run d=%0d: pos=%0d wrap=%b want %0d %b",
                 d, pos, wrap, ep, ew);
      end
      if (d >= 33 && an === 4'b1110) begin
        seen = 1;
        vectors++;
        if (seg !== S_O) begin
          errors++; $display("FAIL right_dig0: seg=%b want %b", seg, S_O);
        end
      end
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL right_dig0_seen: got 0 want 1");
    end
  endtask

  task automatic test_collision;
    int         d;
    logic [1:0] ep;
    bit         seen;
    dir = 0; load = 1; msg = MSG_B;
    cyc(1);
    load = 0; msg = MSG_A;
    vectors++;
    if (pos !== 2'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL coll_load: pos=%0d wrap=%b want 0 0", pos, wrap);
    end
    seen = 0;
    d = cnt - t0;
    while (d < 48) begin
      cyc(1);
      d = cnt - t0;
      ep = (d < 48) ? 2'd0 : 2'd1;
      vectors++;
      if (pos !== ep || wrap !== 1'b0) begin
        errors++;
        $display("FAIL coll_run d=%0d: pos=%0d wrap=%b want %0d 0",
                 d, pos, wrap, ep);
      end
      if (d <= 47 && an === 4'b1110) begin
        seen = 1;
        vectors++;
        if (seg !== S_E) begin
          errors++; $display("FAIL coll_newmsg: seg=%b want %b", seg, S_E);
        end
      end
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL coll_newmsg_seen: got 0 want 1");
    end
  endtask

  task automatic test_pause;
    logic [3:0] mask;
    en = 0;
    mask = '0;
    for (int j = 0; j < 20; j++) begin
      cyc(1);
      vectors++;
      if (pos !== 2'd1 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL pause_pos: pos=%0d wrap=%b want 1 0", pos, wrap);
      end
      mask = mask | ~an;
    end
    vectors++;
    if (mask !== 4'b1111) begin
      errors++; $display("FAIL pause_scan: digits=%b want 1111", mask);
    end
  endtask

  task automatic test_reset_mid;
    en = 1;
    cyc(4);
    vectors++;
    if (pos !== 2'd1 || an === 4'b1111) begin
      errors++;
      $display("FAIL mid_pre: pos=%0d an=%b want 1 and active", pos, an);
    end
    rst = 1; load = 1; msg = MSG_A;
    cyc(1);
    rst = 0; load = 0;
    vectors++;
    if (an !== 4'b1111 || seg !== S_BL) begin
      errors++;
      $display("FAIL mid_rst: an=%b seg=%b want 1111 %b", an, seg, S_BL);
    end
    vectors++;
    if (pos !== 2'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_pos: pos=%0d wrap=%b want 0 0", pos, wrap);
    end
    for (int j = 0; j < 12; j++) begin
      cyc(1);
      vectors++;
      if (an !== 4'b1111 || seg !== S_BL || pos !== 2'd0) begin
        errors++;
        $display("FAIL mid_blank: an=%b seg=%b pos=%0d want 1111 %b 0",
                 an, seg, pos, S_BL);
      end
    end
  endtask

  initial begin
    test_reset;
    test_static;
    test_left;
    test_right;
    test_collision;
    test_pause;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
